// File: rtl/fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_frame_ctrl
// Description : Frames a stream of real samples into 2^N-sample blocks for an
//               external FFT core, starts the transform, then reads back the
//               lower half of the spectrum one bin at a time and presents
//               |re|+|im| magnitudes over a valid/ready handshake.
//
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high
//   sample_valid in   qualifies sample
//   sample       in   signed real sample, BIT_WIDTH bits
//   fft_load     out  FFT RAM write strobe (one cycle per accepted sample)
//   add_rd       out  FFT RAM sample / bin address, N bits
//   din          out  sample written into the FFT RAM
//   fft_start    out  one-cycle transform start pulse
//   fft_done     in   transform complete (honoured only while waiting)
//   dout         in   {real, imag} result, valid one cycle after add_rd
//   bin_valid    out  bin_index / bin_mag are valid
//   bin_ready    in   downstream accepts the presented bin
//   bin_index    out  bin number, N-1 bits
//   bin_mag      out  unsigned |re|+|im|, BIT_WIDTH+1 bits
//   frame_done   out  one-cycle pulse after the last bin is accepted
//   overrun      out  sticky: a sample arrived while it could not be taken
//
// Revision    : 1.0  initial release
// ============================================================================
module fft_frame_ctrl #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_valid,
    input  logic [BIT_WIDTH-1:0]   sample,
    output logic                   fft_load,
    output logic [N-1:0]           add_rd,
    output logic [BIT_WIDTH-1:0]   din,
    output logic                   fft_start,
    input  logic                   fft_done,
    input  logic [2*BIT_WIDTH-1:0] dout,
    output logic                   bin_valid,
    input  logic                   bin_ready,
    output logic [N-2:0]           bin_index,
    output logic [BIT_WIDTH:0]     bin_mag,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam logic [2:0] c_ST_LOAD    = 3'd0;
    localparam logic [2:0] c_ST_START   = 3'd1;
    localparam logic [2:0] c_ST_WAIT    = 3'd2;
    localparam logic [2:0] c_ST_RADDR   = 3'd3;
    localparam logic [2:0] c_ST_RWAIT   = 3'd4;
    localparam logic [2:0] c_ST_PRESENT = 3'd5;

    localparam logic [N-1:0]         c_LOAD_LAST = '1;
    localparam logic [N-1:0]         c_LOAD_ONE  = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-2:0]         c_BIN_LAST  = '1;
    localparam logic [N-2:0]         c_BIN_ONE   = {{(N-2){1'b0}}, 1'b1};
    localparam logic [BIT_WIDTH-1:0] c_ONE       = {{(BIT_WIDTH-1){1'b0}}, 1'b1};

    logic [2:0]           r_state;
    logic [2:0]           w_state_next;
    logic [N-1:0]         r_load_cnt;
    logic                 r_frame_full;   // last sample taken, its fft_load cycle in progress
    logic [N-2:0]         r_bin_cnt;
    logic                 r_fft_load;
    logic [N-1:0]         r_add_rd;
    logic [BIT_WIDTH-1:0] r_din;
    logic                 r_bin_valid;
    logic [N-2:0]         r_bin_index;
    logic [BIT_WIDTH:0]   r_bin_mag;
    logic                 r_frame_done;
    logic                 r_overrun;

    logic                 w_accept;
    logic                 w_bin_take;
    logic                 w_last_bin;
    logic [N-2:0]         w_bin_cnt_inc;
    logic [BIT_WIDTH-1:0] w_re;
    logic [BIT_WIDTH-1:0] w_im;
    logic [BIT_WIDTH-1:0] w_re_abs;
    logic [BIT_WIDTH-1:0] w_im_abs;
    logic [BIT_WIDTH:0]   w_mag;

    // During the fft_load cycle of the final sample the frame is already
    // complete, so a sample arriving then is dropped and flagged.
    assign w_accept      = (r_state == c_ST_LOAD) && !r_frame_full && sample_valid;
    assign w_bin_take    = (r_state == c_ST_PRESENT) && r_bin_valid && bin_ready;
    assign w_last_bin    = w_bin_take && (r_bin_cnt == c_BIN_LAST);
    assign w_bin_cnt_inc = r_bin_cnt + c_BIN_ONE;

    // Magnitude is unsigned BIT_WIDTH per component, so the most negative
    // value negates to 2^(BIT_WIDTH-1) without overflow; the sum gains a bit.
    assign w_re     = dout[2*BIT_WIDTH-1:BIT_WIDTH];
    assign w_im     = dout[BIT_WIDTH-1:0];
    assign w_re_abs = w_re[BIT_WIDTH-1] ? (~w_re + c_ONE) : w_re;
    assign w_im_abs = w_im[BIT_WIDTH-1] ? (~w_im + c_ONE) : w_im;
    assign w_mag    = {1'b0, w_re_abs} + {1'b0, w_im_abs};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_LOAD:    if (r_frame_full) w_state_next = c_ST_START;
            c_ST_START:   w_state_next = c_ST_WAIT;
            c_ST_WAIT:    if (fft_done) w_state_next = c_ST_RADDR;
            c_ST_RADDR:   w_state_next = c_ST_RWAIT;
            c_ST_RWAIT:   w_state_next = c_ST_PRESENT;
            c_ST_PRESENT: if (w_bin_take) w_state_next = w_last_bin ? c_ST_LOAD : c_ST_RADDR;
            default:      w_state_next = c_ST_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_LOAD;
            r_load_cnt   <= '0;
            r_frame_full <= 1'b0;
            r_bin_cnt    <= '0;
            r_fft_load   <= 1'b0;
            r_add_rd     <= '0;
            r_din        <= '0;
            r_bin_valid  <= 1'b0;
            r_bin_index  <= '0;
            r_bin_mag    <= '0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_fft_load   <= w_accept;
            r_frame_done <= w_last_bin;

            if (w_accept) begin
                r_din      <= sample;
                r_add_rd   <= r_load_cnt;
                r_load_cnt <= r_load_cnt + c_LOAD_ONE;
                if (r_load_cnt == c_LOAD_LAST) r_frame_full <= 1'b1;
            end else if (r_state == c_ST_LOAD && r_frame_full) begin
                r_frame_full <= 1'b0;
            end

            // The bin address is set up on entry to RADDR so the RAM sees
            // it for the whole RADDR cycle and returns data during RWAIT.
            if (r_state == c_ST_WAIT && fft_done) begin
                r_bin_cnt <= '0;
                r_add_rd  <= '0;
            end

            if (w_bin_take) begin
                if (w_last_bin) begin
                    r_load_cnt <= '0;
                end else begin
                    r_bin_cnt <= w_bin_cnt_inc;
                    r_add_rd  <= {1'b0, w_bin_cnt_inc};
                end
            end

            if (r_state == c_ST_RWAIT) begin
                r_bin_mag   <= w_mag;
                r_bin_index <= r_bin_cnt;
                r_bin_valid <= 1'b1;
            end else if (w_bin_take) begin
                r_bin_valid <= 1'b0;
            end

            if (sample_valid && !w_accept) r_overrun <= 1'b1;
        end
    end

    assign fft_load   = r_fft_load;
    assign add_rd     = r_add_rd;
    assign din        = r_din;
    assign fft_start  = (r_state == c_ST_START);
    assign bin_valid  = r_bin_valid;
    assign bin_index  = r_bin_index;
    assign bin_mag    = r_bin_mag;
    assign frame_done = r_frame_done;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_fft_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_frame_ctrl
// Description : Self-checking bench for fft_frame_ctrl. A transaction-level
//               model predicts loads, start, overrun and the bin sequence;
//               a small array stands in for the FFT result RAM.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fft_frame_ctrl;

    localparam int BW    = 16;
    localparam int NN    = 9;
    localparam int FRAME = 1 << NN;
    localparam int BINS  = 1 << (NN - 1);

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            sample_valid = 1'b0;
    logic [BW-1:0]   sample = '0;
    logic            fft_done = 1'b0;
    logic [2*BW-1:0] dout = '0;
    logic            bin_ready = 1'b0;
    logic            fft_load;
    logic [NN-1:0]   add_rd;
    logic [BW-1:0]   din;
    logic            fft_start;
    logic            bin_valid;
    logic [NN-2:0]   bin_index;
    logic [BW:0]     bin_mag;
    logic            frame_done;
    logic            overrun;

    fft_frame_ctrl #(.BIT_WIDTH(BW), .N(NN)) dut (
        .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample(sample),
        .fft_load(fft_load), .add_rd(add_rd), .din(din), .fft_start(fft_start),
        .fft_done(fft_done), .dout(dout), .bin_valid(bin_valid), .bin_ready(bin_ready),
        .bin_index(bin_index), .bin_mag(bin_mag), .frame_done(frame_done), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // FFT result RAM: registered read, data valid the cycle after the address.
    logic [31:0] mem [0:FRAME-1];
    always @(posedge clk) dout <= mem[add_rd];

    typedef struct {
        logic [31:0] dout;
        int          mag;
    } vec_t;
    vec_t tbl [8];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int mag_of(logic [31:0] d);
        int re;
        int im;
        re = $signed(d[31:16]);
        im = $signed(d[15:0]);
        if (re < 0) re = -re;
        if (im < 0) im = -im;
        return re + im;
    endfunction

    // ---------------- reference model state ----------------
    bit          chk_en  = 1'b0;
    bit          use_tbl = 1'b0;
    bit          e_load  = 1'b0;
    logic [8:0]  e_addr  = '0;
    logic [15:0] e_din   = '0;
    bit [1:0]    st_pipe = '0;
    bit          e_ovr   = 1'b0;
    bit          e_fd    = 1'b0;
    int          load_cnt = 0;
    bit          loading = 1'b1;
    bit          waiting = 1'b0;
    bit          in_read = 1'b0;
    int          exp_bin = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("fft_load", fft_load, e_load);
            if (e_load) begin
                chk("add_rd", add_rd, e_addr);
                chk("din", din, e_din);
            end
            chk("fft_start", fft_start, st_pipe[1]);
            chk("overrun", overrun, e_ovr);
            chk("frame_done", frame_done, e_fd);
            if (!in_read) begin
                chk("bin_valid_idle", bin_valid, 0);
            end else if (bin_valid) begin
                chk("bin_index", bin_index, exp_bin);
                chk("bin_mag", bin_mag, mag_of(mem[exp_bin]));
                if (use_tbl && exp_bin < 8) chk("bin_mag_tbl", bin_mag, tbl[exp_bin].mag);
            end

            // predictions for the next cycle from the inputs the DUT samples next
            e_load = 1'b0;
            e_fd   = 1'b0;
            if (reset) begin
                st_pipe  = '0;
                e_ovr    = 1'b0;
                load_cnt = 0;
                loading  = 1'b1;
                waiting  = 1'b0;
                in_read  = 1'b0;
                exp_bin  = 0;
            end else begin
                if (waiting && fft_done) begin
                    waiting = 1'b0;
                    in_read = 1'b1;
                    exp_bin = 0;
                end
                if (st_pipe[1]) waiting = 1'b1;
                st_pipe = {st_pipe[0], 1'b0};
                if (sample_valid) begin
                    if (loading) begin
                        e_load = 1'b1;
                        e_addr = load_cnt[8:0];
                        e_din  = sample;
                        load_cnt++;
                        if (load_cnt == FRAME) begin
                            load_cnt   = 0;
                            loading    = 1'b0;
                            st_pipe[0] = 1'b1;
                        end
                    end else begin
                        e_ovr = 1'b1;
                    end
                end
                if (in_read && bin_valid && bin_ready) begin
                    if (exp_bin == BINS - 1) begin
                        in_read = 1'b0;
                        e_fd    = 1'b1;
                        loading = 1'b1;
                    end else begin
                        exp_bin++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(string tag);
        chk({tag, "_fft_load"}, fft_load, 0);
        chk({tag, "_fft_start"}, fft_start, 0);
        chk({tag, "_bin_valid"}, bin_valid, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_add_rd"}, add_rd, 0);
        chk({tag, "_din"}, din, 0);
        chk({tag, "_bin_index"}, bin_index, 0);
        chk({tag, "_bin_mag"}, bin_mag, 0);
    endtask

    task automatic load_frame(int n, bit ramp, bit gaps, bit noise);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    sample_valid = 1'b0;
                    fft_done     = noise ? 1'($urandom) : 1'b0;
                    bin_ready    = noise ? 1'($urandom) : 1'b0;
                    tick();
                end
            end
            fft_done     = 1'b0;
            sample_valid = 1'b1;
            sample       = ramp ? 16'(i) : 16'($urandom);
            tick();
        end
        sample_valid = 1'b0;
        bin_ready    = 1'b0;
    endtask

    task automatic run_fft(int dly, bit poke);
        int t = 0;
        while (!fft_start && t < 20) begin
            tick();
            t++;
        end
        if (t == 20) chk("start_timeout", 0, 1);
        fft_done = 1'b1;            // must be ignored outside WAIT
        tick();
        fft_done = 1'b0;
        repeat (dly) tick();
        if (poke) begin
            sample_valid = 1'b1;
            sample       = 16'h5A5A;
            tick();
            sample_valid = 1'b0;
        end
        fft_done = 1'b1;
        tick();
        fft_done = 1'b0;
    endtask

    task automatic readout(int mode);
        int cyc   = 0;
        int stall = 0;
        while (in_read && cyc < 3000) begin
            case (mode)
                1: bin_ready = 1'b1;
                2: begin
                    if (stall < 10) begin
                        bin_ready = 1'b0;
                        if (bin_valid) stall++;
                    end else begin
                        bin_ready = 1'b1;
                    end
                end
                default: bin_ready = 1'($urandom);
            endcase
            tick();
            cyc++;
        end
        bin_ready = 1'b0;
        chk("readout_done", in_read, 0);
        if (mode == 1) chk("throughput", (cyc <= 3 * BINS + 2), 1);
    endtask

    initial begin
        tbl[0] = '{32'h8000_7FFF, 65535};
        tbl[1] = '{32'hFFFF_0001, 2};
        tbl[2] = '{32'h0000_0000, 0};
        tbl[3] = '{32'h8000_8000, 65536};
        tbl[4] = '{32'h7FFF_7FFF, 65534};
        tbl[5] = '{32'h0001_FFFF, 2};
        tbl[6] = '{32'hFF9C_0064, 200};
        tbl[7] = '{32'h1234_0000, 4660};
        for (int i = 0; i < FRAME; i++) mem[i] = $urandom;
        for (int i = 0; i < 8; i++) mem[i] = tbl[i].dout;

        reset = 1'b1;
        tick();
        chk_en = 1'b1;
        tick();
        reset_checks("por");
        reset = 1'b0;

        // Frame A: ramp samples back to back, table magnitudes, full-rate readout
        use_tbl = 1'b1;
        load_frame(FRAME, 1'b1, 1'b0, 1'b0);
        run_fft(3, 1'b0);
        readout(1);
        use_tbl = 1'b0;

        // Frame B: random samples with gaps, sample during WAIT, stalled readout
        for (int i = 0; i < FRAME; i++) mem[i] = $urandom;
        load_frame(FRAME, 1'b0, 1'b1, 1'b0);
        run_fft(4, 1'b1);
        readout(2);

        // Frame C: noise on fft_done/bin_ready while loading, random readout
        for (int i = 0; i < FRAME; i++) mem[i] = $urandom;
        load_frame(FRAME, 1'b0, 1'b1, 1'b1);
        run_fft(0, 1'b0);
        readout(0);

        // Reset mid-load, with sample_valid in the same cycle
        load_frame(100, 1'b0, 1'b1, 1'b0);
        sample_valid = 1'b1;
        sample       = 16'h1111;
        reset        = 1'b1;
        tick();
        sample_valid = 1'b0;
        reset_checks("rst_load");
        tick();
        reset = 1'b0;

        // Full frame after reset, then reset mid-readout
        load_frame(FRAME, 1'b1, 1'b0, 1'b0);
        run_fft(2, 1'b0);
        repeat (100) begin
            bin_ready = 1'($urandom);
            tick();
        end
        reset = 1'b1;
        tick();
        reset_checks("rst_read");
        tick();
        reset     = 1'b0;
        bin_ready = 1'b0;
        load_frame(4, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fft_frame_ctrl.md
FFT_FRAME_CTRL -- requirements
Module: fft_frame_ctrl

Interface
REQ-001 Parameter BIT_WIDTH, default 16, sample and component width.
REQ-002 Parameter N, default 9, log2 of frame length (frame = 2^N samples).
REQ-003 The block SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- sample_valid  in  1  one-cycle qualifier for sample.
- sample  in  BIT_WIDTH  signed two's-complement real sample.
- fft_load  out  1  FFT RAM load strobe.
- add_rd  out  N  FFT sample/bin address.
- din  out  BIT_WIDTH  sample written to the FFT.
- fft_start  out  1  one-cycle FFT start pulse.
- fft_done  in  1  FFT complete (level or pulse).
- dout  in  2*BIT_WIDTH  FFT result {real[31:16], imag[15:0]}, valid 1 cycle after add_rd.
- bin_valid  out  1  bin output valid.
- bin_ready  in  1  downstream accepts a bin.
- bin_index  out  N-1  bin number, 0..2^(N-1)-1.
- bin_mag  out  BIT_WIDTH+1  unsigned |re|+|im|.
- frame_done  out  1  one-cycle pulse after the last bin is accepted.
- overrun  out  1  sticky flag: a sample was dropped.

Function
REQ-004 The FSM SHALL have states LOAD, START, WAIT, RADDR, RWAIT, PRESENT.
REQ-005 LOAD: on sample_valid, the block SHALL register din=sample and add_rd=load count, assert fft_load for exactly the next cycle, and increment the count.
- Load latency is 1 cycle.
- Back-to-back samples are accepted every cycle.
REQ-006 Once the 2^N-th sample is accepted (count wraps 2^N-1 -> 0), the FSM SHALL go to START after its fft_load cycle completes.
REQ-007 START SHALL assert fft_start for exactly one cycle and then go to WAIT.
- fft_load SHALL be 0 in every state other than LOAD.
REQ-008 WAIT SHALL hold until fft_done is sampled high, then go to RADDR with bin count 0.
- fft_done while in any other state SHALL be ignored.
REQ-009 RADDR SHALL drive add_rd = {1'b0, bin count}, then go to RWAIT.
REQ-010 RWAIT SHALL capture dout into a holding register, then go to PRESENT.
REQ-011 bin_mag SHALL equal abs(real)+abs(imag), computed at full width.
- abs(-2^(BIT_WIDTH-1)) = 2^(BIT_WIDTH-1); no saturation.
- bin_mag, bin_index and bin_valid SHALL be registered.
REQ-012 PRESENT SHALL hold bin_valid=1 with bin_mag and bin_index stable until bin_valid && bin_ready.
- If more bins remain, the FSM SHALL increment the bin count and go to RADDR.
- After bin 2^(N-1)-1 is accepted, the FSM SHALL pulse frame_done for one cycle and go to LOAD with load count 0.
REQ-013 Throughput SHALL be at least 1 bin per 3 cycles when bin_ready is held high.
REQ-014 sample_valid in any state other than LOAD SHALL drop the sample and set overrun=1.
- overrun SHALL clear only on reset.
REQ-015 add_rd SHALL hold its last value when not in LOAD or RADDR.
- din SHALL hold its last value outside LOAD.
REQ-016 bin_valid SHALL be 0 in every state except PRESENT.

Reset
REQ-017 Reset asserted in any state, including mid-load, mid-FFT or mid-readout, SHALL on the next edge:
- put the FSM in LOAD;
- clear the load and bin counts;
- clear fft_load, fft_start, bin_valid, frame_done and overrun;
- set add_rd=0, din=0, bin_index=0, bin_mag=0.
REQ-018 After reset, the first accepted sample SHALL be written to address 0; samples from an interrupted frame are discarded.
REQ-019 Reset SHALL take priority over sample_valid, fft_done and bin_ready in the same cycle.

Verification
REQ-020 Scenario: 512 consecutive sample_valid cycles with sample=k -> fft_load high for 512 cycles with add_rd=k and din=k, each 1 cycle after its input; then a single fft_start pulse.
REQ-021 Scenario: fft_done while in WAIT with dout=0x8000_7FFF at bin 0 -> bin_mag=65535 (0xFFFF), bin_index=0.
- dout=0xFFFF_0001 -> bin_mag=2.
REQ-022 Scenario: bin_ready held low for 10 cycles in PRESENT -> bin_valid, bin_mag and bin_index stable for all 10 cycles; the bin count advances only on the accept cycle.
REQ-023 Scenario: bin_ready held high -> bins 0..255 delivered in order; frame_done pulses once, one cycle after bin 255 is accepted; the FSM returns to LOAD.
REQ-024 Scenario: sample_valid during WAIT -> overrun=1 and stays 1 across the next frame; no fft_load is asserted.
REQ-025 Scenario: reset after 100 samples loaded, then 512 samples -> the first post-reset fft_load has add_rd=0, and fft_start follows the 512th post-reset sample.
